pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register, successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_sat_cnt.sv | 12 +
 rtl/pipe_stage_reg.sv | 88 ++++++++
 tb/tb_pipe_stage_reg.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: stage-register state encoding and per-stage payload structs used to size DATA_W.
package pipe_pkg;
    typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] ctrl;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic [26:0] ctrl;
    } exmem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } memwb_t;

    // Widest stage payload sets the default register width.
    localparam int PIPE_DATA_W = $bits(idex_t);
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: W-bit up-counter with synchronous clear that sticks at its maximum value.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    always_ff @(posedge clk)
        o_cnt <= i_clr ? '0 : (i_inc && !(&o_cnt)) ? o_cnt + 1'b1 : o_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush-to-bubble and stall counter.
// Define PIPE_SKID_EN to add a second skid entry that removes the out_ready -> in_ready path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    pipe_state_t       r_state;
    logic [DATA_W-1:0] r_head;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_stall;

    assign out_valid  = r_state != PS_EMPTY;
    assign out_data   = r_head;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_stall    = out_valid && !out_ready && !flush;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] r_skid;

    assign in_ready = r_state != PS_SKID;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_state <= PS_EMPTY;
            r_head  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            case (r_state)
                PS_EMPTY: if (w_in_xfer) begin
                    r_head  <= in_data;
                    r_state <= PS_FULL;
                end
                PS_FULL: if (w_in_xfer && w_out_xfer) begin
                    r_head <= in_data;
                end else if (w_in_xfer) begin
                    r_skid  <= in_data;
                    r_state <= PS_SKID;
                end else if (w_out_xfer) begin
                    r_state <= PS_EMPTY;
                end
                PS_SKID: if (w_out_xfer) begin
                    r_head  <= r_skid;
                    r_state <= PS_FULL;
                end
                default: r_state <= PS_EMPTY;
            endcase
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    // The head keeps its last payload after draining; only reset and flush restore RESET_VAL.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_state <= PS_EMPTY;
            r_head  <= RESET_VAL;
        end else if (w_in_xfer) begin
            r_head  <= in_data;
            r_state <= PS_FULL;
        end else if (w_out_xfer) begin
            r_state <= PS_EMPTY;
        end
    end
`endif

    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .i_clr (RST),
        .i_inc (w_stall),
        .o_cnt (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue-based model.
// Honours PIPE_SKID_EN to select the two-entry model.
module tb_pipe_stage_reg;
    localparam int          DW = 32;
    localparam int          CW = 4;
    localparam logic [31:0] RV = 32'h5A5A_0000;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] q[$];
    logic [31:0] m_last;
    int          m_cnt;

    pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model across the edge.
    task automatic cyc(input logic r, input logic iv, input logic [31:0] d, input logic fl, input logic ordy);
        logic        eir, inx, outx;
        logic [31:0] eod;
        RST = r; in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
        #1;
        eir = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
        eod = (q.size() > 0) ? q[0] : m_last;
        chk("in_ready", {31'b0, in_ready}, {31'b0, eir});
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("out_data", out_data, eod);
        chk("stall_cnt", {28'b0, stall_cnt}, m_cnt);
        inx  = iv && eir;
        outx = q.size() > 0 && ordy;
        @(posedge CLK);
        #1;
        if (r) begin
            q.delete(); m_last = RV; m_cnt = 0;
        end else if (fl) begin
            q.delete(); m_last = RV;
        end else begin
            if (q.size() > 0 && !ordy && m_cnt < (1 << CW) - 1) m_cnt++;
            if (outx) m_last = q.pop_front();
            if (inx) q.push_back(d);
        end
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; flush = 1'b0; out_ready = 1'b0;
        @(posedge CLK);
        #1;
        q.delete(); m_last = RV; m_cnt = 0;
        cyc(1, 1, 32'hDEAD_BEEF, 0, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, RV);
        chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        cyc(0, 1, 32'd1, 0, 1);
        chk("stream_1", out_data, 32'd1);
        cyc(0, 1, 32'd2, 0, 1);
        chk("stream_2", out_data, 32'd2);
        cyc(0, 1, 32'd3, 0, 1);
        chk("stream_3", out_data, 32'd3);
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        chk("stream_stall", {28'b0, stall_cnt}, 32'd0);
        cyc(0, 0, 32'd0, 0, 1);

        cyc(0, 1, 32'd5, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'd6, 0, 0);
        chk("bp_data", out_data, 32'd5);
        chk("bp_stall", {28'b0, stall_cnt}, 32'd4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 32'd0, 0, 1);

        cyc(0, 1, 32'd7, 0, 0);
        chk("flush_pre", out_data, 32'd7);
        cyc(0, 1, 32'd8, 1, 0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_data", out_data, RV);
        for (int i = 0; i < 2; i++) cyc(0, 0, 32'd0, 0, 1);
        chk("flush_stall_kept", {28'b0, stall_cnt}, 32'd4);

        cyc(0, 1, 32'h11, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 32'd0, 0, 0);
        chk("sat_stall", {28'b0, stall_cnt}, 32'd15);
        for (int i = 0; i < 2; i++) cyc(0, 0, 32'd0, 0, 1);

        if (CAP == 2) begin
            cyc(0, 1, 32'h9, 0, 0);
            cyc(0, 1, 32'hA, 0, 0);
            chk("skid_in_ready", {31'b0, in_ready}, 32'd0);
            chk("skid_head", out_data, 32'h9);
            cyc(0, 0, 32'd0, 0, 1);
            chk("skid_second", out_data, 32'hA);
            cyc(0, 0, 32'd0, 0, 1);
            chk("skid_empty", {31'b0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(63) == 0, 1'($urandom), $urandom,
                $urandom_range(15) == 0, $urandom_range(3) != 0);

        cyc(1, 0, 32'd0, 0, 0);
        chk("end_rst_stall", {28'b0, stall_cnt}, 32'd0);
        chk("end_rst_data", out_data, RV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
